// File: rtl/score_display_ctrl.sv
// Score tracking and display controller for the snake game: counts food, keeps the session
// high score, flashes the final score after game over and feeds an iterative BCD converter.
module score_display_ctrl #(
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned MAX_SCORE    = 140,
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned FLASH_CYCLES = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  goodColl,
  input  logic                  badColl,
  input  logic                  start,
  output logic [SCORE_W-1:0]    length,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  blank,
  output logic                  busy,
  output logic                  isGameComplete,
  output logic                  newHigh
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned FlashW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned CntW   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  localparam logic [HoldW-1:0]   HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [FlashW-1:0]  FlashLast = FlashW'(FLASH_CYCLES - 1);
  localparam logic [CntW-1:0]    CntLast   = CntW'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] MaxScore  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);

  localparam logic [1:0] StPlay   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
  localparam logic [1:0] StShowHi = 2'd2;

  logic [1:0]          r_state;
  logic [SCORE_W-1:0]  r_curr;
  logic [SCORE_W-1:0]  r_high;
  logic [SCORE_W-1:0]  r_final;
  logic                r_gc;
  logic                r_nh;
  logic                r_blank;
  logic [HoldW-1:0]    r_hold;
  logic [FlashW-1:0]   r_flash;

  logic                r_busy;
  logic [SCORE_W-1:0]  r_src;
  logic [SCORE_W-1:0]  r_shift;
  logic [4*DIGITS-1:0] r_acc;
  logic [CntW-1:0]     r_cnt;
  logic [4*DIGITS-1:0] r_bcd;

  logic [SCORE_W-1:0]  w_inc;
  logic [SCORE_W-1:0]  w_disp;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_acc_nxt;

  assign w_inc = r_curr + ScoreOne;

  always_comb begin
    case (r_state)
      StHold:   w_disp = r_final;
      StShowHi: w_disp = r_high;
      default:  w_disp = r_curr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StPlay;
      r_curr  <= '0;
      r_high  <= '0;
      r_final <= '0;
      r_gc    <= 1'b0;
      r_nh    <= 1'b0;
      r_blank <= 1'b0;
      r_hold  <= '0;
      r_flash <= '0;
    end else begin
      case (r_state)
        StPlay: begin
          if (badColl) begin
            r_final <= r_curr;
            r_nh    <= (r_curr == r_high) && (r_curr != '0);
            r_gc    <= 1'b1;
            r_blank <= 1'b0;
            r_hold  <= '0;
            r_flash <= '0;
            r_state <= StHold;
          end else if (goodColl) begin
            r_curr <= w_inc;
            if (w_inc > r_high) r_high <= w_inc;
            // Reaching the winning score ends the game on the same edge.
            if (w_inc == MaxScore) begin
              r_final <= w_inc;
              r_nh    <= (w_inc >= r_high);
              r_gc    <= 1'b1;
              r_blank <= 1'b0;
              r_hold  <= '0;
              r_flash <= '0;
              r_state <= StHold;
            end
          end
        end
        StHold, StShowHi: begin
          if (start) begin
            r_state <= StPlay;
            r_curr  <= '0;
            r_gc    <= 1'b0;
            r_nh    <= 1'b0;
            r_blank <= 1'b0;
            r_hold  <= '0;
            r_flash <= '0;
          end else if (r_state == StHold) begin
            if (r_hold == HoldLast) begin
              r_state <= StShowHi;
              r_blank <= 1'b0;
              r_hold  <= '0;
              r_flash <= '0;
            end else begin
              r_hold <= r_hold + HoldW'(1);
              if (r_flash == FlashLast) begin
                r_flash <= '0;
                r_blank <= ~r_blank;
              end else begin
                r_flash <= r_flash + FlashW'(1);
              end
            end
          end
        end
        default: r_state <= StPlay;
      endcase
    end
  end

  // Shift-and-add-3: correct nibbles before each left shift.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_acc_nxt = {w_adj[4*DIGITS-2:0], r_shift[SCORE_W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_src   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else if (!r_busy) begin
      if (w_disp != r_src) begin
        r_src   <= w_disp;
        r_shift <= w_disp;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
    end else begin
      r_acc   <= w_acc_nxt;
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt + CntW'(1);
      if (r_cnt == CntLast) begin
        r_bcd  <= w_acc_nxt;
        r_busy <= 1'b0;
      end
    end
  end

  assign length         = r_curr;
  assign bcd            = r_bcd;
  assign blank          = r_blank;
  assign busy           = r_busy;
  assign isGameComplete = r_gc;
  assign newHigh        = r_nh;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: expected BCD results are queued by the stimulus and
// popped by a monitor on every completed conversion; state outputs are checked directly.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        goodColl = 1'b0;
  logic        badColl = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  length;
  logic [11:0] bcd;
  logic        blank;
  logic        busy;
  logic        isGameComplete;
  logic        newHigh;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  logic prev_busy = 1'b0;

  score_display_ctrl #(
    .SCORE_W(8), .MAX_SCORE(140), .DIGITS(3), .HOLD_CYCLES(20), .FLASH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .goodColl(goodColl), .badColl(badColl), .start(start),
    .length(length), .bcd(bcd), .blank(blank), .busy(busy),
    .isGameComplete(isGameComplete), .newHigh(newHigh)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One goodColl pulse; optionally queue the BCD the converter will produce for the new length.
  task automatic good_pulse(int new_len, bit push, int idle);
    if (push) exp_q.push_back(to_bcd(new_len));
    goodColl = 1'b1;
    tick();
    goodColl = 1'b0;
    tick(idle);
  endtask

  // Monitor: a falling busy outside reset is a completed conversion.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got bcd 0x%0h with nothing expected at %0t", bcd, $time);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (bcd !== e) begin
            n_bad++;
            $display("FAIL sb_bcd: got 0x%0h expected 0x%0h at %0t", bcd, e, $time);
          end
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    int busy_cnt;
    // Reset state
    tick(2);
    check("rst_length", 32'(length), 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gc", 32'(isGameComplete), 0);
    rst = 1'b0;
    tick(3);
    check("idle_bcd", 32'(bcd), 12'h000);
    check("idle_busy", 32'(busy), 0);

    // Counting: 12 pulses, the last one timed precisely
    for (int i = 1; i <= 11; i++) good_pulse(i, 1'b1, 11);
    check("len11", 32'(length), 11);
    good_pulse(12, 1'b1, 0);
    check("len12", 32'(length), 12);
    busy_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (k == 8) check("bcd_at8", 32'(bcd), 12'h011);
    end
    check("bcd_at9", 32'(bcd), 12'h012);
    check("busy_cycles", 32'(busy_cnt), 8);
    tick(3);

    // First game over at 12
    badColl = 1'b1;
    tick();
    badColl = 1'b0;
    check("g1_gc", 32'(isGameComplete), 1);
    check("g1_newhigh", 32'(newHigh), 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("g1_blank", 32'(blank), (k < 20) ? 32'((k / 4) % 2) : 0);
      check("g1_bcd", 32'(bcd), 12'h012);
    end
    check("g1_gc_hi", 32'(isGameComplete), 1);
    tick(3);

    // Second, lower game
    exp_q.push_back(12'h000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g2_len0", 32'(length), 0);
    check("g2_gc0", 32'(isGameComplete), 0);
    tick(11);
    for (int i = 1; i <= 5; i++) good_pulse(i, 1'b1, 11);
    badColl = 1'b1;
    tick();
    badColl = 1'b0;
    check("g2_gc", 32'(isGameComplete), 1);
    check("g2_newhigh", 32'(newHigh), 0);
    exp_q.push_back(12'h012);
    tick(10);
    check("g2_final_bcd", 32'(bcd), 12'h005);
    tick(22);
    check("g2_high_bcd", 32'(bcd), 12'h012);
    check("g2_len5", 32'(length), 5);
    exp_q.push_back(12'h000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("g2_len_after", 32'(length), 0);
    tick(12);

    // goodColl + badColl together at 7, then start during HOLD
    for (int i = 1; i <= 7; i++) good_pulse(i, 1'b1, 11);
    goodColl = 1'b1;
    badColl = 1'b1;
    tick();
    goodColl = 1'b0;
    badColl = 1'b0;
    check("sim_len", 32'(length), 7);
    check("sim_gc", 32'(isGameComplete), 1);
    tick(5);
    check("sim_final_bcd", 32'(bcd), 12'h007);
    check("sim_blank1", 32'(blank), 1);
    exp_q.push_back(12'h000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_abort_gc", 32'(isGameComplete), 0);
    check("hold_abort_blank", 32'(blank), 0);
    tick(12);

    // Rapid pulses during conversion: 1 is converted, 2..4 skipped, 5 last
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h005);
    goodColl = 1'b1;
    tick(5);
    goodColl = 1'b0;
    tick(25);
    check("rapid_len", 32'(length), 5);
    check("rapid_bcd", 32'(bcd), 12'h005);

    // Reset mid-conversion (6 never completes)
    good_pulse(6, 1'b0, 3);
    check("mid_conv_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("rstc_busy", 32'(busy), 0);
    check("rstc_bcd", 32'(bcd), 0);
    check("rstc_len", 32'(length), 0);
    tick();
    rst = 1'b0;
    tick(3);
    check("rstc_idle_busy", 32'(busy), 0);
    check("rstc_idle_bcd", 32'(bcd), 12'h000);

    // Reset mid-HOLD
    for (int i = 1; i <= 3; i++) good_pulse(i, 1'b1, 11);
    badColl = 1'b1;
    tick();
    badColl = 1'b0;
    tick(6);
    check("hold_blank_pre", 32'(blank), 1);
    check("hold_nh_pre", 32'(newHigh), 1);
    rst = 1'b1;
    #1;
    check("rsth_gc", 32'(isGameComplete), 0);
    check("rsth_nh", 32'(newHigh), 0);
    check("rsth_blank", 32'(blank), 0);
    check("rsth_bcd", 32'(bcd), 0);
    check("rsth_len", 32'(length), 0);
    tick();
    rst = 1'b0;
    tick(3);

    // Win at 140
    for (int i = 1; i <= 139; i++) good_pulse(i, 1'b1, 11);
    check("win_gc_pre", 32'(isGameComplete), 0);
    good_pulse(140, 1'b1, 0);
    check("win_gc", 32'(isGameComplete), 1);
    check("win_len", 32'(length), 140);
    check("win_nh", 32'(newHigh), 1);
    good_pulse(141, 1'b0, 1);
    good_pulse(141, 1'b0, 1);
    check("win_len_held", 32'(length), 140);
    tick(25);
    check("win_hi_bcd", 32'(bcd), 12'h140);
    check("win_len_end", 32'(length), 140);

    tick(10);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Parametrised score-tracking and display controller for the snake game. It counts food collisions, tracks the session high score and detects game completion. At game over it flashes the final score for a programmable hold time, then shows the high score. It sits between the collision logic and the seven-segment driver and drives a packed BCD digit bus through a multi-cycle double-dabble converter.

## Interface
Parameters:
- SCORE_W, default 8: width of all score registers and of `length`.
- MAX_SCORE, default 140: winning score. Must satisfy MAX_SCORE < 2^SCORE_W.
- DIGITS, default 3: BCD digits on `bcd`. Must satisfy 10^DIGITS > 2^SCORE_W - 1.
- HOLD_CYCLES, default 100_000_000: clocks the final score stays on display after game over. Must be ≥ 1.
- FLASH_CYCLES, default 12_500_000: clocks per `blank` toggle during hold. Must be ≥ 1.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- goodColl, input, 1: single-cycle pulse; snake ate food.
- badColl, input, 1: single-cycle pulse; snake hit wall or itself.
- start, input, 1: single-cycle pulse; begin a new game after game over.
- length, output, SCORE_W: current snake length (= current score), registered.
- bcd, output, 4*DIGITS: packed BCD of the displayed value; digit 0 (ones) in bits [3:0].
- blank, output, 1: display blank request; toggles during HOLD.
- busy, output, 1: converter mid-conversion; `bcd` holds its previous value.
- isGameComplete, output, 1: high from game over until `start` is accepted.
- newHigh, output, 1: high while the final score of the last game set a new high score.

## Operation
- Reset values:
  - All outputs are 0.
  - currScore, highScore and finalScore are 0.
  - FSM is in PLAY.
  - Converter is idle with source value 0.
  - Hold and flash counters are 0.
- FSM states:
  - **PLAY**
    - badColl: finalScore←currScore; newHigh←(currScore == highScore && currScore != 0); isGameComplete←1; go to HOLD. currScore is not incremented this cycle.
    - goodColl without badColl: currScore←currScore+1. highScore←max(highScore, currScore+1) in the same edge.
    - If currScore+1 == MAX_SCORE: apply the same game-over actions with finalScore = MAX_SCORE, then go to HOLD.
    - goodColl and badColl in the same cycle: badColl wins.
    - start is ignored in PLAY.
  - **HOLD**
    - Displayed value is finalScore.
    - Flash counter runs; `blank` inverts each time it reaches FLASH_CYCLES-1, then the counter clears.
    - Hold counter counts to HOLD_CYCLES-1, then the FSM goes to SHOW_HI with blank←0.
    - Collisions are ignored.
    - start aborts the hold and goes to PLAY.
  - **SHOW_HI**
    - Displayed value is highScore; blank = 0.
    - Collisions are ignored.
    - start → PLAY.
  - **start accepted** (HOLD or SHOW_HI): currScore←0, length←0, isGameComplete←0, newHigh←0, blank←0, both counters clear. highScore is retained.
- `length` equals currScore at all times; it is updated on the same edge as currScore.
- Displayed value:
  - PLAY → currScore.
  - HOLD → finalScore.
  - SHOW_HI → highScore.
- Converter (iterative double-dabble, shift-and-add-3):
  - **Start condition:** converter idle and displayed value ≠ last converted source. The converter then latches the displayed value and raises busy.
  - **Iterations:** SCORE_W, one per clock. Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts left 1.
  - **Completion:** on the final iteration edge, `bcd` is written with the whole result at once and busy drops. Partial results never appear on `bcd`.
  - **Source changes mid-conversion:** the current conversion completes. The converter restarts on the next idle cycle with the latest displayed value. Intermediate values may be skipped; the final `bcd` always matches the settled displayed value.
- Arithmetic:
  - All score arithmetic is unsigned, SCORE_W wide.
  - currScore never exceeds MAX_SCORE and never wraps.
- Reset asserted mid-operation (any state, mid-conversion) returns everything to the reset values immediately.

## Timing
- Collision → length/currScore/highScore: 1 edge.
- Collision → isGameComplete/newHigh/state change: 1 edge.
- Displayed value change at edge E0:
  - Converter loads at E1.
  - `bcd` is valid at E1+SCORE_W (SCORE_W+1 edges after E0).
  - busy is high from E1 through E1+SCORE_W-1.
- Worst case, change arriving just after a load: `bcd` is valid ≤ 2·SCORE_W+2 edges after the change.
- Game over at edge G:
  - First `blank` toggle at G+FLASH_CYCLES.
  - SHOW_HI entered at G+HOLD_CYCLES.
- start → PLAY: 1 edge.

## Test plan
Benches use SCORE_W=8, MAX_SCORE=140, DIGITS=3, HOLD_CYCLES=20, FLASH_CYCLES=4.
- **Reset:** assert rst mid-conversion and mid-HOLD → all outputs 0 and state PLAY within the same cycle as assertion; release → converter idle with bcd=0x000.
- **Counting:** 12 goodColl pulses → length=12; bcd=0x012 exactly 9 edges after the last pulse; busy high for 8 cycles.
- **Game over, first game:** badColl at score 12 → isGameComplete=1, newHigh=1. blank toggles at +4, +8, …; bcd=0x012 throughout. At +20 → blank=0, bcd shows high 0x012.
- **Lower second game:** start, 5 goodColl, badColl → newHigh=0. Final bcd=0x005 flashes, then bcd=0x012 after hold; length=5 until start, then 0.
- **Win:** 140 goodColl pulses → isGameComplete=1 on the 140th, length=140, highScore=140, bcd=0x140. Further goodColl pulses leave length=140.
- **Simultaneous events:** goodColl+badColl at score 7 → finalScore=7, not 8. start during HOLD → PLAY next edge, blank=0. Rapid goodColl during conversion → final bcd equals the final length.
